seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the successor to the fixed two-bit "11" detector. It samples a qualified bit stream and matches a runtime-programmable pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection. It sits on serial link/decoder front-ends and drives a registered one-cycle detect pulse plus an optional saturating match counter.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
COUNT_W, 16, width of match_count
RST_PATTERN, 2'b11 zero-extended to MAX_LEN, pattern active out of reset
RST_LEN, 2, pattern length active out of reset

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  qualifies in_bit; the stream advances only when high
in_bit  in  1  serial data bit
cfg_load  in  1  one-cycle strobe; captures cfg_* and restarts matching
cfg_pattern  in  MAX_LEN  pattern, bit [len-1] = oldest bit, bit 0 = newest
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
count_clr  in  1  synchronous clear of match_count
detected  out  1  registered one-cycle match pulse
match_count  out  COUNT_W  saturating count of matches

Behaviour:
- Reset (async, reset_n=0): history=0, fill=0, state=FILLING, pattern=RST_PATTERN, len=RST_LEN, overlap=1, detected=0, match_count=0.
- Config: cfg_len 0 is taken as 1; cfg_len > MAX_LEN is clamped to MAX_LEN. On cfg_load, pattern/len/overlap are registered, and history, fill and state become 0/0/FILLING. detected is 0 next cycle. match_count is unchanged.
- cfg_load and in_valid in the same cycle: load wins and the bit is discarded.
- Shift: on in_valid, hist_next = {history[MAX_LEN-2:0], in_bit}. fill increments and saturates at MAX_LEN.
- Match (in a valid cycle): fill_next >= len and hist_next[len-1:0] == pattern[len-1:0].
- Latency: detected goes high the cycle after the completing bit is sampled, for exactly one cycle. It is 0 in any cycle without in_valid.
- FSM, two states:
  - FILLING (fill < len): no match possible. Moves to ARMED when fill_next >= len.
  - ARMED: match evaluated on every valid bit.
  - On a match with overlap=0: fill is cleared to 0 and the FSM goes to FILLING. History is kept but ignored until refilled.
  - On a match with overlap=1: the FSM stays in ARMED.
- match_count: +1 per match, saturates at 2^COUNT_W-1 with no wrap. count_clr has priority over a simultaneous match, giving a result of 0.
- Reset mid-stream discards partial progress immediately. A pulse already in flight is killed.

Optional Feature:
- Macro: SEQ_DETECTOR_COUNT_EN.
- Defined: match_count logic present as above.
- Undefined: no counter flops; match_count tied to 0; count_clr ignored. Detection behaviour is identical.

Decomposition:
- Shared package seq_det_pkg holds: state enum (FILLING, ARMED), the clamp-length function, and RST_PATTERN/RST_LEN defaults.
- One sub-module, seq_det_sat_counter: a COUNT_W saturating counter with clear priority, instantiated only under SEQ_DETECTOR_COUNT_EN.

Test Plan:
- Default config after reset, stream 1,1,1 (in_valid=1) -> detected pulses after bits 2 and 3; match_count=2.
- cfg_load pattern 4'b1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; count +2.
- Same pattern and stream, overlap=0 -> single pulse after bit 4; count +1.
- Stream 1,0,1 then in_valid low for 5 cycles, then 1 (pattern 1011) -> no pulse during the gap; pulse exactly one cycle after the final valid bit.
- Feed 1,0,1 of 1011, pull reset_n low mid-cycle, release, send 1 -> no pulse; detected=0 and match_count=0 while in reset. Separately: cfg_load together with in_valid -> bit discarded, fill=0.
- COUNT_W=2, 5 matches -> match_count saturates at 3. count_clr together with a match -> 0. With the macro undefined -> match_count stays 0 throughout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, reset defaults and length clamping for seq_detector_param.
`default_nettype none

package seq_det_pkg;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } det_state_e;

  localparam int         DEF_MAX_LEN     = 8;
  localparam int         DEF_RST_LEN     = 2;
  localparam logic [1:0] DEF_RST_PATTERN = 2'b11;

  // A zero length is treated as a single-bit pattern; oversize lengths saturate.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: saturating up-counter, synchronous clear has priority over increment.
`default_nettype none

module seq_det_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with overlap control.
// Optional match counter built only when SEQ_DETECTOR_COUNT_EN is defined.
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                       MAX_LEN     = DEF_MAX_LEN,
  parameter int                       COUNT_W     = 16,
  parameter logic [MAX_LEN-1:0]       RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                       RST_LEN     = DEF_RST_LEN,
  localparam int                      LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detected,
  output logic [COUNT_W-1:0] match_count
);

  det_state_e         state, state_next;
  logic [MAX_LEN-1:0] history, pattern;
  logic [LW-1:0]      fill, len;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_next, len_mask;
  logic [LW-1:0]      fill_inc, len_clamped;
  logic               shift_en, bits_equal, match;

  assign shift_en    = in_valid && !cfg_load;
  assign hist_next   = {history[MAX_LEN-2:0], in_bit};
  assign fill_inc    = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
  assign len_mask    = ~({MAX_LEN{1'b1}} << len);
  assign bits_equal  = ((hist_next ^ pattern) & len_mask) == '0;
  assign len_clamped = LW'(clamp_len(int'(cfg_len), MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILLING;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = FILLING;
    end else if (in_valid) begin
      if (match && !overlap)  state_next = FILLING;
      else if (fill_inc >= len) state_next = ARMED;
    end
  end

  // The bit that completes the first window already counts, so FILLING can match on its exit bit.
  always_comb begin
    match = shift_en && bits_equal && ((state == ARMED) || (fill_inc >= len));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      history  <= '0;
      fill     <= '0;
      pattern  <= RST_PATTERN;
      len      <= LW'(RST_LEN);
      overlap  <= 1'b1;
      detected <= 1'b0;
    end else begin
      detected <= match;
      if (cfg_load) begin
        history <= '0;
        fill    <= '0;
        pattern <= cfg_pattern;
        len     <= len_clamped;
        overlap <= cfg_overlap;
      end else if (in_valid) begin
        history <= hist_next;
        fill    <= (match && !overlap) ? '0 : fill_inc;
      end
    end
  end

  logic unused_hist_msb;
  assign unused_hist_msb = history[MAX_LEN-1];

`ifdef SEQ_DETECTOR_COUNT_EN
  if (1) begin : g_counter
    seq_det_sat_counter #(
      .WIDTH (COUNT_W)
    ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (count_clr),
      .inc     (match),
      .count   (match_count)
    );
  end
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed checks against a bit-queue reference model.
`default_nettype none

module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int COUNT_W = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid, in_bit, cfg_load, cfg_overlap, count_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               detected;
  logic [COUNT_W-1:0] match_count;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .detected    (detected),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: bits received since the last restart, newest at the back.
  bit                 q[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit window_matches();
    int n = q.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (q[n-1-i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = MAX_LEN'(2'b11);
    m_len = 2;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  // One clock: apply inputs, advance model, check registered outputs after the edge.
  task automatic step(input logic v, input logic b, input logic ld, input logic clr);
    bit m = 1'b0;
    in_valid = v; in_bit = b; cfg_load = ld; count_clr = clr;
    if (ld) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
      m_ovl = cfg_overlap;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      m = window_matches();
      if (m && !m_ovl) q.delete();
    end
`ifdef SEQ_DETECTOR_COUNT_EN
    if (clr)                     m_cnt = 0;
    else if (m && m_cnt < CNT_MAX) m_cnt++;
`endif
    @(posedge clk); #1;
    check("detected", 32'(detected), 32'(m));
    check("match_count", 32'(match_count), 32'(m_cnt));
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len, input logic ovl);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted and released mid-cycle.
  task automatic do_reset();
    in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("rst_detected", 32'(detected), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    @(posedge clk); #3 reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_detected", 32'(detected), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_detected", 32'(detected), 32'd0);
    check("init_count", 32'(match_count), 32'd0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Default "11" pattern, overlapping
    send(16'b111, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 1011 overlapping then non-overlapping
    load(8'b1011, 4'd4, 1'b1);
    send(16'b1011011, 7);
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011011, 7);

    // Gap in the stream
    load(8'b1011, 4'd4, 1'b1);
    send(16'b101, 3);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    send(16'b1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation and clear racing a match
    load(8'b11, 4'd2, 1'b1);
    send(16'b111111, 6);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send(16'b11, 2);

    // Load together with a valid bit discards that bit
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send(16'b11, 2);

    // Length boundaries: 0 acts as 1, 15 clamps to MAX_LEN
    load(8'b1, 4'd0, 1'b1);
    send(16'b1101, 4);
    load(8'hA5, 4'd15, 1'b0);
    send(16'hA5A5, 16);

    // Reset mid-stream, and a pulse already in flight
    load(8'b1011, 4'd4, 1'b1);
    send(16'b101, 3);
    do_reset();
    send(16'b1, 1);
    send(16'b1, 1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic ld, v, b, clr;
      ld  = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 9) < 7);
      b   = 1'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      if (ld) begin
        cfg_len     = LW'($urandom_range(0, 4));
        cfg_pattern = MAX_LEN'($urandom);
        cfg_overlap = 1'($urandom);
      end
      step(v, b, ld, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
